// File: rtl/fir_result_writer.sv
// FIR result writer: buffers scaled FIR results in a small FIFO and drains them
// into a downstream FIFO, with a flush handshake and a sticky overflow flag.
module fir_result_writer #(
    parameter int DATA_WIDTH = 32,
    parameter int BUF_DEPTH  = 4,
    parameter int GAIN_SHIFT = 0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [DATA_WIDTH-1:0]        dotProd,
    input  logic                         done,
    output logic                         stall,
    input  logic                         flush,
    output logic                         flush_done,
    output logic [DATA_WIDTH-1:0]        out_dout,
    output logic                         out_wr_en,
    input  logic                         out_full,
    output logic                         overflow,
    output logic [$clog2(BUF_DEPTH):0]   count
);

    localparam int AW = $clog2(BUF_DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = DATA_WIDTH + 8;
    localparam logic [CW-1:0] FULL_CNT = CW'(BUF_DEPTH);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_FLUSH      = 2'd1,
        ST_FLUSH_DONE = 2'd2
    } state_t;

    // Left shift by GAIN_SHIFT with saturation; 8 guard bits cover the largest shift.
    function automatic logic [DATA_WIDTH-1:0] scale_sat(input logic [DATA_WIDTH-1:0] v);
        logic [EW-1:0]         ext;
        logic [EW-1:0]         shf;
        logic [DATA_WIDTH-1:0] res;
        ext = {{8{v[DATA_WIDTH-1]}}, v};
        shf = ext << GAIN_SHIFT;
        if (shf[EW-1:DATA_WIDTH-1] == {(EW-DATA_WIDTH+1){shf[EW-1]}}) begin
            res = shf[DATA_WIDTH-1:0];
        end else if (shf[EW-1]) begin
            res = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            res = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
        return res;
    endfunction

    state_t                state_r;
    state_t                state_nxt_s;
    logic [AW-1:0]         wr_ptr_r;
    logic [AW-1:0]         rd_ptr_r;
    logic [CW-1:0]         count_r;
    logic                  overflow_r;
    logic [DATA_WIDTH-1:0] buf_r [BUF_DEPTH];
    logic                  stall_s;
    logic                  flush_done_s;
    logic                  capture_s;
    logic                  drain_s;

    // FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (flush) begin
                    state_nxt_s = ST_FLUSH;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (count_r == CW'(0)) begin
                    state_nxt_s = ST_FLUSH_DONE;
                end else begin
                    state_nxt_s = ST_FLUSH;
                end
            end
            ST_FLUSH_DONE: state_nxt_s = ST_RUN;
            default:       state_nxt_s = ST_RUN;
        endcase
    end

    // FSM outputs; the full decision uses the registered count only
    always_comb begin
        stall_s      = 1'b0;
        flush_done_s = 1'b0;
        case (state_r)
            ST_RUN:        stall_s = (count_r == FULL_CNT);
            ST_FLUSH:      stall_s = 1'b1;
            ST_FLUSH_DONE: begin
                stall_s      = 1'b1;
                flush_done_s = 1'b1;
            end
            default:       stall_s = 1'b1;
        endcase
    end

    // Capture and drain qualifiers
    always_comb begin
        capture_s = 1'b0;
        drain_s   = 1'b0;
        if (done && !stall_s) begin
            capture_s = 1'b1;
        end else begin
            capture_s = 1'b0;
        end
        if ((count_r != CW'(0)) && !out_full) begin
            drain_s = 1'b1;
        end else begin
            drain_s = 1'b0;
        end
    end

    // Pointers, occupancy and sticky overflow
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_r   <= AW'(0);
            rd_ptr_r   <= AW'(0);
            count_r    <= CW'(0);
            overflow_r <= 1'b0;
        end else begin
            if (capture_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (drain_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            if (capture_s && !drain_s) begin
                count_r <= count_r + CW'(1);
            end else if (!capture_s && drain_s) begin
                count_r <= count_r - CW'(1);
            end
            if (done && stall_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Result storage; contents are don't-care while count is zero
    always_ff @(posedge clock) begin
        if (capture_s) begin
            buf_r[wr_ptr_r] <= scale_sat(dotProd);
        end
    end

    assign stall      = stall_s;
    assign flush_done = flush_done_s;
    assign out_wr_en  = drain_s;
    assign out_dout   = (count_r != CW'(0)) ? buf_r[rd_ptr_r] : {DATA_WIDTH{1'b0}};
    assign overflow   = overflow_r;
    assign count      = count_r;

endmodule

// File: tb/tb_fir_result_writer.sv
// Scoreboard bench for fir_result_writer: two instances (gain 0 and gain 4)
// share stimulus and are checked against a queue-based reference model.
module tb_fir_result_writer;

    logic        clock;
    logic        reset;
    logic [31:0] dot_prod;
    logic        done;
    logic        flush;
    logic        out_full;

    logic        stall0, flush_done0, wr0, ovf0;
    logic [31:0] dout0;
    logic [2:0]  count0;
    logic        stall4, flush_done4, wr4, ovf4;
    logic [31:0] dout4;
    logic [2:0]  count4;

    fir_result_writer #(.DATA_WIDTH(32), .BUF_DEPTH(4), .GAIN_SHIFT(0)) dut0 (
        .clock(clock), .reset(reset), .dotProd(dot_prod), .done(done), .stall(stall0),
        .flush(flush), .flush_done(flush_done0), .out_dout(dout0), .out_wr_en(wr0),
        .out_full(out_full), .overflow(ovf0), .count(count0));

    fir_result_writer #(.DATA_WIDTH(32), .BUF_DEPTH(4), .GAIN_SHIFT(4)) dut4 (
        .clock(clock), .reset(reset), .dotProd(dot_prod), .done(done), .stall(stall4),
        .flush(flush), .flush_done(flush_done4), .out_dout(dout4), .out_wr_en(wr4),
        .out_full(out_full), .overflow(ovf4), .count(count4));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: buffer contents, flush phase (0 run, 1 flushing, 2 done), overflow
    logic [31:0] mq[$];
    int          mphase = 0;
    logic        movf   = 1'b0;
    // Scoreboard of expected writes for each instance
    logic [31:0] sb0[$];
    logic [31:0] sb4[$];

    function automatic logic [31:0] ref_scale(input logic [31:0] v, input int g);
        longint x;
        x = longint'($signed(v)) * (longint'(1) << g);
        if (x > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (x < -64'sd2147483648) return 32'h8000_0000;
        return x[31:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_status(input logic full_in);
        logic exp_stall, exp_wr;
        exp_stall = (mq.size() == 4) || (mphase != 0);
        exp_wr    = (mq.size() != 0) && !full_in;
        chk("stall0", 32'(stall0), 32'(exp_stall));
        chk("stall4", 32'(stall4), 32'(exp_stall));
        chk("count0", 32'(count0), 32'(mq.size()));
        chk("count4", 32'(count4), 32'(mq.size()));
        chk("wr_en0", 32'(wr0), 32'(exp_wr));
        chk("wr_en4", 32'(wr4), 32'(exp_wr));
        chk("overflow", 32'(ovf0), 32'(movf));
        chk("flush_done", 32'(flush_done0), 32'(mphase == 2));
        if (mq.size() == 0) begin
            chk("dout0_idle", dout0, 32'h0);
            chk("dout4_idle", dout4, 32'h0);
        end
    endtask

    // One clock cycle: drive at the falling edge, check, then advance the model
    task automatic cycle(input logic d_done, input logic [31:0] d, input logic d_full, input logic d_flush);
        logic exp_stall, exp_wr;
        int   nphase;
        @(negedge clock);
        done = d_done; dot_prod = d; out_full = d_full; flush = d_flush;
        #1;
        check_status(d_full);
        exp_stall = (mq.size() == 4) || (mphase != 0);
        exp_wr    = (mq.size() != 0) && !d_full;
        nphase = mphase;
        if (mphase == 0 && d_flush) nphase = 1;
        else if (mphase == 1 && mq.size() == 0) nphase = 2;
        else if (mphase == 2) nphase = 0;
        if (exp_wr) void'(mq.pop_front());
        if (d_done && !exp_stall) begin
            mq.push_back(d);
            sb0.push_back(ref_scale(d, 0));
            sb4.push_back(ref_scale(d, 4));
        end else if (d_done) begin
            movf = 1'b1;
        end
        mphase = nphase;
    endtask

    // Assert reset between clock edges, check immediately, release later
    task automatic apply_reset(input int hold);
        @(negedge clock);
        #3;
        done = 1'b0; flush = 1'b0;
        reset = 1'b0;
        mq.delete(); sb0.delete(); sb4.delete();
        mphase = 0; movf = 1'b0;
        #1;
        check_status(out_full);
        repeat (hold) @(negedge clock);
        #3;
        check_status(out_full);
        reset = 1'b1;
    endtask

    task automatic idle(input int n, input logic full_in);
        repeat (n) cycle(1'b0, 32'h0, full_in, 1'b0);
    endtask

    // Monitor: pops the scoreboard whenever a downstream write is presented
    initial begin
        forever begin
            @(negedge clock);
            #2;
            if (wr0 || wr4) begin
                chk("wr_en_match", 32'(wr4), 32'(wr0));
                if (sb0.size() == 0) begin
                    chk("unexpected_write", 32'(1), 32'(0));
                end else begin
                    chk("dout0", dout0, sb0.pop_front());
                    chk("dout4", dout4, sb4.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; done = 1'b0; flush = 1'b0; out_full = 1'b0; dot_prod = 32'h0;
        repeat (3) @(negedge clock);
        #3;
        check_status(1'b0);
        reset = 1'b1;

        // Pass-through and saturation values
        cycle(1'b1, 32'h0000_0010, 1'b0, 1'b0);
        cycle(1'b1, 32'hFFFF_FFF0, 1'b0, 1'b0);
        idle(3, 1'b0);
        cycle(1'b1, 32'h1000_0000, 1'b0, 1'b0);
        cycle(1'b1, 32'hF000_0000, 1'b0, 1'b0);
        cycle(1'b1, 32'h0000_0003, 1'b0, 1'b0);
        idle(4, 1'b0);

        // Backpressure: fifth result dropped, then 1..4 drain in order
        for (int i = 1; i <= 5; i++) cycle(1'b1, 32'(i), 1'b1, 1'b0);
        idle(2, 1'b1);
        idle(6, 1'b0);

        // Full buffer with a same-cycle drain still drops the new result
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'(100 + i), 1'b1, 1'b0);
        cycle(1'b1, 32'h0000_0063, 1'b0, 1'b0);
        idle(5, 1'b0);

        // Flush while blocked downstream, then release
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'(200 + i), 1'b1, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b1);
        cycle(1'b1, 32'h0000_0BAD, 1'b1, 1'b1);
        idle(2, 1'b1);
        idle(7, 1'b0);

        // Asynchronous reset with buffered entries
        cycle(1'b1, 32'h0000_0011, 1'b1, 1'b0);
        cycle(1'b1, 32'h0000_0022, 1'b1, 1'b0);
        apply_reset(2);
        idle(4, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] d;
            case ($urandom_range(0, 2))
                0:       d = 32'($urandom_range(0, 255)) - 32'd128;
                1:       d = {{4{$urandom_range(0, 1) == 1 ? 1'b1 : 1'b0}}, 28'($urandom)};
                default: d = $urandom;
            endcase
            cycle($urandom_range(0, 1) == 1, d, $urandom_range(0, 9) < 3,
                  $urandom_range(0, 19) == 0);
        end

        for (int i = 0; i < 40 && (mq.size() != 0 || mphase != 0); i++) idle(1, 1'b0);
        idle(2, 1'b0);
        chk("scoreboard_empty", 32'(sb0.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_result_writer.md
FIR_RESULT_WRITER -- requirements
Module: fir_result_writer

Interface
REQ-001 Parameter DATA_WIDTH, default 32, sample width in bits (signed two's complement).
REQ-002 Parameter BUF_DEPTH, default 4, internal result buffer entries (power of two, >= 2).
REQ-003 Parameter GAIN_SHIFT, default 0, arithmetic left-shift applied to each captured result (0..8).
REQ-004 clock  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 dotProd  input  DATA_WIDTH  FIR result, valid in the cycle done is high.
REQ-007 done  input  1  one-cycle strobe; a new result is presented.
REQ-008 stall  output  1  high when a result presented this cycle will not be accepted.
REQ-009 flush  input  1  request to drain the buffer to the output FIFO.
REQ-010 flush_done  output  1  one-cycle pulse when a flush completes.
REQ-011 out_dout  output  DATA_WIDTH  data to downstream FIFO.
REQ-012 out_wr_en  output  1  write strobe to downstream FIFO.
REQ-013 out_full  input  1  downstream FIFO full.
REQ-014 overflow  output  1  sticky flag, a result was dropped.
REQ-015 count  output  clog2(BUF_DEPTH)+1  current buffer occupancy.

Function
REQ-016 FSM states: RUN, FLUSH, FLUSH_DONE; reset state RUN.
REQ-017 RUN: flush=1 moves to FLUSH next cycle; otherwise stay in RUN.
REQ-018 FLUSH: stay while count != 0; move to FLUSH_DONE in the cycle after count reaches 0.
REQ-019 FLUSH_DONE: flush_done=1 for exactly this cycle; unconditional return to RUN.
REQ-020 stall = (count == BUF_DEPTH) or state != RUN; combinational from registered state/count.
REQ-021 Capture: done=1 and stall=0 writes the scaled result at the write pointer; count increments unless a drain occurs in the same cycle.
REQ-022 Drop: done=1 and stall=1 discards the result and sets overflow; overflow clears only on reset.
REQ-023 Full decision uses registered count; a drain in the same cycle does not free a slot for that cycle's done.
REQ-024 Scaling: result = dotProd shifted left by GAIN_SHIFT, saturated to the signed DATA_WIDTH range (max 0x7FFFFFFF, min 0x80000000 at 32 bits); GAIN_SHIFT=0 passes the value unchanged.
REQ-025 Drain: out_wr_en = (count != 0) and not out_full; combinational, in all states.
REQ-026 out_dout = entry at the read pointer whenever count != 0; otherwise 0.
REQ-027 Drain advances the read pointer; a drain without a capture in the same cycle decrements count.
REQ-028 Simultaneous capture and drain leaves count unchanged; both pointers advance.
REQ-029 Pointers wrap modulo BUF_DEPTH; order out = order captured (FIFO).
REQ-030 Latency: a captured result is presented on out_dout no earlier than 1 cycle after its done strobe.
REQ-031 flush asserted while already in FLUSH or FLUSH_DONE is ignored.

Reset
REQ-032 reset=0 asynchronously forces: state RUN, pointers 0, count 0, overflow 0, flush_done 0, out_wr_en 0, out_dout 0, stall 0.
REQ-033 Reset mid-operation discards buffered results; none are written out after reset release.
REQ-034 Outputs remain at their reset values while reset=0; normal operation starts at the first rising edge after release.

Verification
REQ-035 Pass-through: GAIN_SHIFT=0, out_full=0, done with 0x00000010, 0xFFFFFFF0 -> out_wr_en pulses in the same order, out_dout 0x00000010 then 0xFFFFFFF0, count returns to 0.
REQ-036 Saturation: GAIN_SHIFT=4, dotProd 0x10000000 -> out_dout 0x7FFFFFFF; dotProd 0xF0000000 -> 0x80000000; dotProd 0x00000003 -> 0x00000030.
REQ-037 Backpressure/overflow: out_full=1, 5 done strobes with 1..5 -> stall high after the 4th, 5th dropped, overflow=1; release out_full -> outputs 1,2,3,4 only.
REQ-038 Simultaneous: count=4, out_full=0, done on the same cycle as a drain -> result dropped, count becomes 3, overflow=1.
REQ-039 Flush: 3 entries buffered, out_full=1, flush pulse -> stall=1, no flush_done; release out_full -> 3 writes, then flush_done for exactly 1 cycle, state RUN, stall=0.
REQ-040 Async reset: 2 entries buffered, reset low between clock edges -> count=0, out_wr_en=0 immediately; no writes after release.
